// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter that shares the MAC host register port among NUM_REQ requesters.
// Define MAC_REG_ARB_PRIO0_EN to give requester 0 absolute priority over the round robin.
module mac_reg_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STROBE_CYCLES  = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                    Clk_reg,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [NUM_REQ*8-1:0]    req_addr,
  input  logic [NUM_REQ*16-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      ack,
  output logic [15:0]             rdata,
  output logic                    busy,
  output logic [2:0]              gnt_idx,
  output logic                    CSB,
  output logic                    WRB,
  output logic [7:0]              CA,
  output logic [15:0]             CD_in,
  input  logic [15:0]             CD_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] STROBE  = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [1:0]         state_reg;
  logic [3:0]         cnt_reg;
  logic [2:0]         ptr_reg;
  logic [2:0]         gnt_reg;
  logic               wr_reg;
  logic               csb_reg;
  logic               wrb_reg;
  logic [7:0]         ca_reg;
  logic [15:0]        cd_in_reg;
  logic [15:0]        rdata_reg;
  logic [NUM_REQ-1:0] ack_reg;

  // Requester fields padded out to 8 slots so a 3-bit index is always in range.
  logic [7:0]  req_ext;
  logic [7:0]  wr_ext;
  logic [7:0]  addr_arr  [8];
  logic [15:0] wdata_arr [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_used
        assign req_ext[gi]   = req[gi];
        assign wr_ext[gi]    = req_wr[gi];
        assign addr_arr[gi]  = req_addr[8*gi +: 8];
        assign wdata_arr[gi] = req_wdata[16*gi +: 16];
      end else begin : g_unused
        assign req_ext[gi]   = 1'b0;
        assign wr_ext[gi]    = 1'b0;
        assign addr_arr[gi]  = 8'h00;
        assign wdata_arr[gi] = 16'h0000;
      end
    end
  endgenerate

  logic       win_found;
  logic [2:0] win_idx;
  logic       ptr_upd;
  logic [3:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_found && req_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
    ptr_upd = win_found;
`ifdef MAC_REG_ARB_PRIO0_EN
    // Host CPU overrides the rotation and leaves the pointer where it was.
    if (req_ext[0]) begin
      win_found = 1'b1;
      win_idx   = 3'd0;
      ptr_upd   = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge Clk_reg) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ptr_reg   <= 3'(NUM_REQ - 1);
      gnt_reg   <= 3'd0;
      wr_reg    <= 1'b0;
      csb_reg   <= 1'b1;
      wrb_reg   <= 1'b1;
      ca_reg    <= 8'h00;
      cd_in_reg <= 16'h0000;
      rdata_reg <= 16'h0000;
      ack_reg   <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg <= SETUP;
            gnt_reg   <= win_idx;
            wr_reg    <= wr_ext[win_idx];
            ca_reg    <= addr_arr[win_idx];
            cd_in_reg <= wdata_arr[win_idx];
            if (ptr_upd) ptr_reg <= win_idx;
          end
        end
        SETUP: begin
          state_reg <= STROBE;
          csb_reg   <= 1'b0;
          wrb_reg   <= ~wr_reg;
          cnt_reg   <= 4'd0;
        end
        STROBE: begin
          if (cnt_reg == 4'(STROBE_CYCLES - 1)) begin
            // Last strobe cycle: capture read data so it is valid alongside ack.
            state_reg <= RECOVER;
            csb_reg   <= 1'b1;
            wrb_reg   <= 1'b1;
            cnt_reg   <= 4'd0;
            ack_reg   <= NUM_REQ'(1) << gnt_reg;
            if (!wr_reg) rdata_reg <= CD_out;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          if (cnt_reg == 4'(RECOVER_CYCLES - 1)) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
      endcase
    end
  end

  assign ack     = ack_reg;
  assign rdata   = rdata_reg;
  assign busy    = (state_reg != IDLE);
  assign gnt_idx = gnt_reg;
  assign CSB     = csb_reg;
  assign WRB     = wrb_reg;
  assign CA      = ca_reg;
  assign CD_in   = cd_in_reg;

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Scoreboard bench for mac_reg_arbiter: default instance plus a STROBE=1/RECOVER=3 instance.
// Expectations follow MAC_REG_ARB_PRIO0_EN when the bench is built with it.
module tb_mac_reg_arbiter;

  typedef struct {
    int          idx;
    logic [15:0] rd;
    int          cy;
  } exp_t;

  logic        Clk_reg;
  logic        Reset;
  int          cyc;
  int          n_cmp;
  int          n_bad;

  // Default-parameter instance
  logic [3:0]  req, req_wr, ack;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [15:0] rdata, CD_in, CD_out, rd_val;
  logic        busy, CSB, WRB;
  logic [2:0]  gnt_idx;
  logic [7:0]  CA;

  // Swept instance
  logic [1:0]  b_req, b_req_wr, b_ack;
  logic [15:0] b_req_addr;
  logic [31:0] b_req_wdata;
  logic [15:0] b_rdata, b_CD_in, b_CD_out;
  logic        b_busy, b_CSB, b_WRB;
  logic [2:0]  b_gnt_idx;
  logic [7:0]  b_CA;

  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] exp_rd;
  int          exp_ord[5];
  int          prio_ord[4];

  mac_reg_arbiter dut (
    .Clk_reg(Clk_reg), .Reset(Reset), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .busy(busy), .gnt_idx(gnt_idx), .CSB(CSB), .WRB(WRB), .CA(CA),
    .CD_in(CD_in), .CD_out(CD_out)
  );

  mac_reg_arbiter #(.NUM_REQ(2), .STROBE_CYCLES(1), .RECOVER_CYCLES(3)) dut_b (
    .Clk_reg(Clk_reg), .Reset(Reset), .req(b_req), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .ack(b_ack), .rdata(b_rdata),
    .busy(b_busy), .gnt_idx(b_gnt_idx), .CSB(b_CSB), .WRB(b_WRB), .CA(b_CA),
    .CD_in(b_CD_in), .CD_out(b_CD_out)
  );

  // MAC model: read data only appears while chip select is active.
  assign CD_out   = (CSB == 1'b0) ? rd_val : 16'hDEAD;
  assign b_CD_out = (b_CSB == 1'b0) ? 16'h0055 : 16'hBEEF;

  initial Clk_reg = 1'b0;
  always #5 Clk_reg = ~Clk_reg;

  initial cyc = 0;
  always @(posedge Clk_reg) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", nm, act, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge Clk_reg);
      #1;
    end
  endtask

  task automatic issue(input int i, input logic wr, input logic [7:0] a, input logic [15:0] d);
    req_wr[i]            = wr;
    req_addr[8*i +: 8]   = a;
    req_wdata[16*i +: 16] = d;
    req[i]               = 1'b1;
  endtask

  task automatic push_a(input int idx, input int cy);
    exp_t e;
    e.idx = idx;
    e.rd  = exp_rd;
    e.cy  = cy;
    qa.push_back(e);
  endtask

  // Monitors: pop one expectation for every ack the DUT presents.
  always @(negedge Clk_reg) begin
    exp_t e;
    if (ack !== 4'b0000) begin
      if (qa.size() == 0) begin
        chk("a_ack_unexpected", 32'(ack), 32'h0);
      end else begin
        e = qa.pop_front();
        chk("a_ack_vec", 32'(ack), 32'(1) << e.idx);
        chk("a_ack_gnt", 32'(gnt_idx), 32'(e.idx));
        chk("a_ack_rdata", 32'(rdata), 32'(e.rd));
        chk("a_ack_cycle", 32'(cyc), 32'(e.cy));
      end
    end
  end

  always @(negedge Clk_reg) begin
    exp_t e;
    if (b_ack !== 2'b00) begin
      if (qb.size() == 0) begin
        chk("b_ack_unexpected", 32'(b_ack), 32'h0);
      end else begin
        e = qb.pop_front();
        chk("b_ack_vec", 32'(b_ack), 32'(1) << e.idx);
        chk("b_ack_rdata", 32'(b_rdata), 32'(e.rd));
        chk("b_ack_cycle", 32'(cyc), 32'(e.cy));
      end
    end
  end

  initial begin
    int n;
    exp_t eb;
    n_cmp = 0; n_bad = 0;
    Reset = 1'b1;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; rd_val = 16'h0000;
    b_req = '0; b_req_wr = '0; b_req_addr = '0; b_req_wdata = '0;
    exp_rd = 16'h0000;
`ifdef MAC_REG_ARB_PRIO0_EN
    exp_ord  = '{0, 0, 0, 0, 0};
    prio_ord = '{0, 0, 0, 0};
`else
    exp_ord  = '{0, 1, 2, 3, 0};
    prio_ord = '{3, 0, 3, 0};
`endif
    wait_cyc(3);
    chk("rst_csb", 32'(CSB), 32'h1);
    chk("rst_wrb", 32'(WRB), 32'h1);
    chk("rst_ca", 32'(CA), 32'h0);
    chk("rst_cd_in", 32'(CD_in), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt", 32'(gnt_idx), 32'h0);
    Reset = 1'b0;
    wait_cyc(5);

    // Single write from requester 1
    n = cyc;
    issue(1, 1'b1, 8'h22, 16'h0004);
    push_a(1, n + 4);
    wait_cyc(n + 1);
    chk("wr_setup_ca", 32'(CA), 32'h22);
    chk("wr_setup_cd", 32'(CD_in), 32'h0004);
    chk("wr_setup_csb", 32'({CSB, WRB}), 32'h3);
    chk("wr_setup_gnt", 32'(gnt_idx), 32'h1);
    wait_cyc(n + 2);
    chk("wr_strobe1", 32'({CSB, WRB}), 32'h0);
    wait_cyc(n + 3);
    chk("wr_strobe2", 32'({CSB, WRB}), 32'h0);
    wait_cyc(n + 4);
    chk("wr_recover", 32'({CSB, WRB, busy}), 32'h7);
    req[1] = 1'b0;
    wait_cyc(n + 5);
    chk("wr_busy_low", 32'(busy), 32'h0);

    // Single read from requester 2, then a write that must not touch rdata
    n = cyc;
    rd_val = 16'h0002;
    issue(2, 1'b0, 8'h22, 16'hFFFF);
    exp_rd = 16'h0002;
    push_a(2, n + 4);
    wait_cyc(n + 2);
    chk("rd_strobe1", 32'({CSB, WRB}), 32'h1);
    wait_cyc(n + 3);
    chk("rd_strobe2", 32'({CSB, WRB}), 32'h1);
    wait_cyc(n + 4);
    req[2] = 1'b0;
    wait_cyc(n + 5);
    n = cyc;
    rd_val = 16'h7777;
    issue(3, 1'b1, 8'h10, 16'h1234);
    push_a(3, n + 4);
    wait_cyc(n + 1);
    chk("wr2_setup_ca", 32'(CA), 32'h10);
    wait_cyc(n + 4);
    req[3] = 1'b0;
    wait_cyc(n + 5);

    // Contention: all four requesters held high
    n = cyc;
    for (int i = 0; i < 4; i++) issue(i, 1'b1, 8'(8'h40 + i), 16'(16'h0100 * i));
    for (int k = 0; k < 5; k++) push_a(exp_ord[k], n + 4 + 5 * k);
    wait_cyc(n + 24);
    req = '0;
    wait_cyc(n + 30);

    // Requesters 0 and 3 held high
    n = cyc;
    issue(0, 1'b1, 8'h01, 16'hAAAA);
    issue(3, 1'b1, 8'h03, 16'h3333);
    for (int k = 0; k < 4; k++) push_a(prio_ord[k], n + 4 + 5 * k);
    wait_cyc(n + 19);
    req = '0;
    wait_cyc(n + 25);

    // Reset during the second strobe cycle of a write from requester 2
    n = cyc;
    issue(2, 1'b1, 8'h55, 16'h5555);
    wait_cyc(n + 3);
    chk("mid_strobe_csb", 32'(CSB), 32'h0);
    Reset = 1'b1;
    req[2] = 1'b0;
    wait_cyc(n + 4);
    chk("rst_mid_csb_wrb", 32'({CSB, WRB}), 32'h3);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ack", 32'(ack), 32'h0);
    Reset = 1'b0;
    exp_rd = 16'h0000;
    n = cyc;
    issue(0, 1'b1, 8'h0A, 16'h000A);
    issue(3, 1'b1, 8'h0B, 16'h000B);
    push_a(0, n + 4);
    push_a(3, n + 9);
    wait_cyc(n + 1);
    chk("post_rst_gnt", 32'(gnt_idx), 32'h0);
    wait_cyc(n + 4);
    req[0] = 1'b0;
    wait_cyc(n + 9);
    req[3] = 1'b0;
    wait_cyc(n + 11);

    // Swept instance: one strobe cycle, three recovery cycles
    n = cyc;
    b_req_wr[1] = 1'b0;
    b_req_addr[15:8] = 8'h33;
    b_req[1] = 1'b1;
    eb.idx = 1; eb.rd = 16'h0055; eb.cy = n + 3;
    qb.push_back(eb);
    eb.cy = n + 9;
    qb.push_back(eb);
    wait_cyc(n + 1);
    chk("b_setup", 32'({b_CSB, b_busy, b_CA}), 32'h333);
    wait_cyc(n + 2);
    chk("b_strobe", 32'({b_CSB, b_WRB}), 32'h1);
    wait_cyc(n + 3);
    chk("b_recover1", 32'(b_CSB), 32'h1);
    wait_cyc(n + 9);
    b_req[1] = 1'b0;
    wait_cyc(n + 14);

    chk("a_missing_acks", 32'(qa.size()), 32'h0);
    chk("b_missing_acks", 32'(qb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
